// File: rtl/peripheral_ahb_master_arbiter.sv
// -----------------------------------------------------------------------------
// peripheral_ahb_master_arbiter
//
// Purpose:
//   Shares one AHB-Lite master port between NREQ local requesters. A
//   round-robin arbiter accepts one request at a time. Each accepted request
//   becomes a single NONSEQ/SINGLE transfer. The address phase and the data
//   phase never overlap: HTRANS returns to IDLE while the data phase runs.
//   Peak rate is one transfer every three cycles.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req_valid/ready   per-requester handshake; ready is one-hot or zero and is
//                     only raised while the arbiter is idle
//   req_addr/we/size/wdata
//                     flattened per-requester request fields (slice i = req i)
//   rsp_valid         one-hot completion pulse, one cycle after data phase end
//   rsp_rdata/err     HRDATA / HRESP sampled at completion (valid with rsp_valid)
//   H*                AHB-Lite master signals
// -----------------------------------------------------------------------------
module peripheral_ahb_master_arbiter #(
  parameter int         NREQ       = 2,
  parameter int         HADDR_SIZE = 64,
  parameter int         HDATA_SIZE = 64,
  parameter logic [3:0] HPROT_VAL  = 4'b0011
) (
  input  logic                         clk,
  input  logic                         rst,

  input  logic [NREQ-1:0]              req_valid,
  output logic [NREQ-1:0]              req_ready,
  input  logic [NREQ*HADDR_SIZE-1:0]   req_addr,
  input  logic [NREQ-1:0]              req_we,
  input  logic [NREQ*3-1:0]            req_size,
  input  logic [NREQ*HDATA_SIZE-1:0]   req_wdata,

  output logic [NREQ-1:0]              rsp_valid,
  output logic [HDATA_SIZE-1:0]        rsp_rdata,
  output logic                         rsp_err,

  output logic                         HSEL,
  output logic [HADDR_SIZE-1:0]        HADDR,
  output logic [HDATA_SIZE-1:0]        HWDATA,
  output logic                         HWRITE,
  output logic [2:0]                   HSIZE,
  output logic [2:0]                   HBURST,
  output logic [3:0]                   HPROT,
  output logic [1:0]                   HTRANS,
  output logic                         HMASTLOCK,
  input  logic                         HREADY,
  input  logic                         HRESP,
  input  logic [HDATA_SIZE-1:0]        HRDATA
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic       HRESP_ERROR   = 1'b1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0]            state_q,      state_d;
  logic [GW-1:0]         last_grant_q, last_grant_d;
  logic [HDATA_SIZE-1:0] wdata_q,      wdata_d;
  logic [1:0]            htrans_q,     htrans_d;
  logic                  hsel_q,       hsel_d;
  logic [HADDR_SIZE-1:0] haddr_q,      haddr_d;
  logic [HDATA_SIZE-1:0] hwdata_q,     hwdata_d;
  logic                  hwrite_q,     hwrite_d;
  logic [2:0]            hsize_q,      hsize_d;
  logic [NREQ-1:0]       rsp_valid_q,  rsp_valid_d;
  logic [HDATA_SIZE-1:0] rsp_rdata_q,  rsp_rdata_d;
  logic                  rsp_err_q,    rsp_err_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick. The lowest requester above last_grant wins; if none is
  // above it, the search wraps and the lowest requester overall wins. Scanning
  // downward makes the final assignment the lowest index.
  // ---------------------------------------------------------------------------
  logic          any_valid;
  logic          hi_found;
  logic [GW-1:0] lo_idx;
  logic [GW-1:0] hi_idx;
  logic [GW-1:0] grant_idx;
  logic          accept;

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    any_valid = 1'b0;
    hi_found  = 1'b0;
    lo_idx    = '0;
    hi_idx    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        any_valid = 1'b1;
        lo_idx    = GW'(i);
        if (GW'(i) > last_grant_q) begin
          hi_found = 1'b1;
          hi_idx   = GW'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
  end

  // A request asserted during reset is not accepted, so ready stays low too.
  assign accept = !rst && (state_q == ST_IDLE) && any_valid;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (accept && (grant_idx == GW'(i))) req_ready[i] = 1'b1;
    end
  end

  // Fields of the granted requester.
  logic [HADDR_SIZE-1:0] sel_addr;
  logic                  sel_we;
  logic [2:0]            sel_size;
  logic [HDATA_SIZE-1:0] sel_wdata;

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_size  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == GW'(i)) begin
        sel_addr  = req_addr[i*HADDR_SIZE +: HADDR_SIZE];
        sel_we    = req_we[i];
        sel_size  = req_size[i*3 +: 3];
        sel_wdata = req_wdata[i*HDATA_SIZE +: HDATA_SIZE];
      end
    end
  end

  // last_grant also names the owner of the transfer in flight.
  logic [NREQ-1:0] owner_oh;

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (last_grant_q == GW'(i)) owner_oh[i] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Transfer sequencing: IDLE -> ADDR -> DATA -> IDLE
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    wdata_d      = wdata_q;
    htrans_d     = htrans_q;
    hsel_d       = hsel_q;
    haddr_d      = haddr_q;
    hwdata_d     = hwdata_q;
    hwrite_d     = hwrite_q;
    hsize_d      = hsize_q;
    rsp_valid_d  = '0;          // completion is a single-cycle pulse
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      ST_IDLE: begin
        if (any_valid) begin
          state_d      = ST_ADDR;
          last_grant_d = grant_idx;
          wdata_d      = sel_wdata;
          htrans_d     = HTRANS_NONSEQ;
          hsel_d       = 1'b1;
          haddr_d      = sel_addr;
          hwrite_d     = sel_we;
          hsize_d      = sel_size;
        end
      end
      ST_ADDR: begin
        // With HREADY low the address phase is extended unchanged.
        if (HREADY) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          hsel_d   = 1'b0;
          hwdata_d = wdata_q;   // driven on reads as well
        end
      end
      ST_DATA: begin
        // The first cycle of a two-cycle ERROR response has HREADY low and is
        // treated as an ordinary wait state.
        if (HREADY) begin
          state_d     = ST_IDLE;
          rsp_valid_d = owner_oh;
          rsp_rdata_d = HRDATA;
          rsp_err_d   = (HRESP == HRESP_ERROR);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every register samples the values from before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GW'(NREQ - 1);
      wdata_q      <= '0;
      htrans_q     <= HTRANS_IDLE;
      hsel_q       <= 1'b0;
      haddr_q      <= '0;
      hwdata_q     <= '0;
      hwrite_q     <= 1'b0;
      hsize_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wdata_q      <= wdata_d;
      htrans_q     <= htrans_d;
      hsel_q       <= hsel_d;
      haddr_q      <= haddr_d;
      hwdata_q     <= hwdata_d;
      hwrite_q     <= hwrite_d;
      hsize_q      <= hsize_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign HTRANS    = htrans_q;
  assign HSEL      = hsel_q;
  assign HADDR     = haddr_q;
  assign HWDATA    = hwdata_q;
  assign HWRITE    = hwrite_q;
  assign HSIZE     = hsize_q;
  assign HBURST    = HBURST_SINGLE;
  assign HPROT     = HPROT_VAL;
  assign HMASTLOCK = 1'b0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_peripheral_ahb_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_peripheral_ahb_master_arbiter
//
// Purpose:
//   Self-checking bench for peripheral_ahb_master_arbiter. A transaction-level
//   model (one transfer record plus its bus phase) predicts every output each
//   cycle. Directed scenarios pin the model with literal expectations. A
//   randomized phase then exercises arbitration, wait states, errors and reset.
// -----------------------------------------------------------------------------
module tb_peripheral_ahb_master_arbiter;

  localparam int NREQ = 2;
  localparam int AW   = 64;
  localparam int DW   = 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ-1:0]      req_we;
  logic [NREQ*3-1:0]    req_size;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      rsp_valid;
  logic [DW-1:0]        rsp_rdata;
  logic                 rsp_err;
  logic                 HSEL;
  logic [AW-1:0]        HADDR;
  logic [DW-1:0]        HWDATA;
  logic                 HWRITE;
  logic [2:0]           HSIZE;
  logic [2:0]           HBURST;
  logic [3:0]           HPROT;
  logic [1:0]           HTRANS;
  logic                 HMASTLOCK;
  logic                 HREADY;
  logic                 HRESP;
  logic [DW-1:0]        HRDATA;

  peripheral_ahb_master_arbiter #(
    .NREQ(NREQ), .HADDR_SIZE(AW), .HDATA_SIZE(DW), .HPROT_VAL(4'b0011)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_we(req_we), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS),
    .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Scoring
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------------------------------------------------------------------
  // Transaction-level reference model
  // ---------------------------------------------------------------------------
  typedef enum int {P_NONE, P_ADDR, P_DATA} phase_e;

  phase_e          m_phase;
  int              m_owner;
  int              m_last;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic            m_we;
  logic [2:0]      m_size;
  logic [NREQ-1:0] m_rsp;
  logic [DW-1:0]   m_rdata;
  logic            m_err;
  bit              model_valid = 1'b0;

  typedef struct {int cyc; int idx;} grant_t;
  grant_t dut_grants[$];
  bit     rec_en = 1'b0;
  int     cyc    = 0;

  // One clock cycle: compare against the model, advance the model, then move
  // to the next falling edge where the caller drives new inputs.
  task automatic tick();
    int              g;
    logic [NREQ-1:0] exp_ready;
    #1;
    g = -1;
    if (m_phase == P_NONE && !rst) begin
      for (int k = 1; k <= NREQ; k++) begin
        int idx;
        idx = (m_last + k) % NREQ;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;

    if (model_valid) begin
      check("req_ready", req_ready, exp_ready);
      check("HTRANS", HTRANS, (m_phase == P_ADDR) ? 2'b10 : 2'b00);
      check("HSEL", HSEL, m_phase == P_ADDR);
      check("HBURST", HBURST, 3'b000);
      check("HPROT", HPROT, 4'b0011);
      check("HMASTLOCK", HMASTLOCK, 1'b0);
      if (m_phase == P_ADDR) begin
        check("HADDR", HADDR, m_addr);
        check("HWRITE", HWRITE, m_we);
        check("HSIZE", HSIZE, m_size);
      end
      if (m_phase == P_DATA) check("HWDATA", HWDATA, m_wdata);
      check("rsp_valid", rsp_valid, m_rsp);
      if (m_rsp != '0) begin
        check("rsp_rdata", rsp_rdata, m_rdata);
        check("rsp_err", rsp_err, m_err);
      end
    end

    if (rec_en) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) dut_grants.push_back('{cyc: cyc, idx: i});
      end
    end

    if (rst) begin
      m_phase     = P_NONE;
      m_last      = NREQ - 1;
      m_rsp       = '0;
      m_rdata     = '0;
      m_err       = 1'b0;
      model_valid = 1'b1;
    end else begin
      m_rsp = '0;
      case (m_phase)
        P_NONE: if (g >= 0) begin
          m_owner = g;
          m_last  = g;
          m_addr  = req_addr[g*AW +: AW];
          m_we    = req_we[g];
          m_size  = req_size[g*3 +: 3];
          m_wdata = req_wdata[g*DW +: DW];
          m_phase = P_ADDR;
        end
        P_ADDR: if (HREADY) m_phase = P_DATA;
        P_DATA: if (HREADY) begin
          m_rsp[m_owner] = 1'b1;
          m_rdata        = HRDATA;
          m_err          = HRESP;
          m_phase        = P_NONE;
        end
        default: m_phase = P_NONE;
      endcase
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [63:0] a, input logic we,
                         input logic [2:0] sz, input logic [63:0] wd);
    req_addr[i*AW +: AW]  = a;
    req_we[i]             = we;
    req_size[i*3 +: 3]    = sz;
    req_wdata[i*DW +: DW] = wd;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  int exp_order[4] = '{0, 1, 0, 1};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_we    = '0;
    req_size  = '0;
    req_wdata = '0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    m_phase   = P_NONE;
    m_last    = NREQ - 1;
    m_rsp     = '0;
    m_rdata   = '0;
    m_err     = 1'b0;
    @(negedge clk);

    // 1: reset for two cycles
    ticks(2);
    rst = 1'b0;
    #1;
    check("reset.HTRANS", HTRANS, 2'b00);
    check("reset.HSEL", HSEL, 1'b0);
    check("reset.req_ready", req_ready, 2'b00);
    check("reset.rsp_valid", rsp_valid, 2'b00);
    check("reset.HADDR", HADDR, 64'h0);
    check("reset.HWDATA", HWDATA, 64'h0);
    check("reset.rsp_rdata", rsp_rdata, 64'h0);
    tick();

    // 2: zero-wait write from requester 0
    set_req(0, 64'h1000, 1'b1, 3'b011, 64'hA5);
    req_valid = 2'b01;
    #1;
    check("wr.T.req_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    check("wr.T1.HTRANS", HTRANS, 2'b10);
    check("wr.T1.HADDR", HADDR, 64'h1000);
    check("wr.T1.HWRITE", HWRITE, 1'b1);
    check("wr.T1.HSIZE", HSIZE, 3'b011);
    tick();
    #1;
    check("wr.T2.HTRANS", HTRANS, 2'b00);
    check("wr.T2.HWDATA", HWDATA, 64'hA5);
    tick();
    #1;
    check("wr.T3.rsp_valid", rsp_valid, 2'b01);
    check("wr.T3.rsp_err", rsp_err, 1'b0);
    tick();

    // 3: round-robin with both requesters held active after a reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_req(0, 64'h3000, 1'b1, 3'b010, 64'h11);
    set_req(1, 64'h4000, 1'b0, 3'b010, 64'h22);
    req_valid = 2'b11;
    dut_grants.delete();
    rec_en = 1'b1;
    ticks(12);
    rec_en = 1'b0;
    req_valid = 2'b00;
    ticks(3);
    check("rr.count", dut_grants.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < dut_grants.size()) check("rr.order", dut_grants[i].idx, exp_order[i]);
      if (i > 0 && i < dut_grants.size())
        check("rr.spacing", dut_grants[i].cyc - dut_grants[i-1].cyc, 3);
    end

    // 4: read from requester 1 with three data-phase wait states
    set_req(1, 64'h2000, 1'b0, 3'b010, 64'h77);
    req_valid = 2'b10;
    #1;
    check("rd.T.req_ready", req_ready, 2'b10);
    tick();                          // T
    req_valid = 2'b00;
    tick();                          // T+1 address phase
    HREADY = 1'b0;
    ticks(3);                        // T+2..T+4 wait states
    HREADY = 1'b1;
    HRDATA = 64'hDEAD;
    #1;
    check("rd.T5.rsp_valid", rsp_valid, 2'b00);
    check("rd.T5.HWDATA", HWDATA, 64'h77);
    tick();                          // T+5 completion
    HRDATA = 64'h0;
    #1;
    check("rd.T6.rsp_valid", rsp_valid, 2'b10);
    check("rd.T6.rsp_rdata", rsp_rdata, 64'hDEAD);
    tick();

    // 5: two-cycle ERROR response
    set_req(0, 64'h5000, 1'b1, 3'b011, 64'h5A);
    req_valid = 2'b01;
    tick();                          // T
    req_valid = 2'b00;
    tick();                          // T+1
    HRESP  = 1'b1;
    HREADY = 1'b0;
    tick();                          // T+2 first error cycle
    HREADY = 1'b1;
    #1;
    check("err.T3.rsp_valid", rsp_valid, 2'b00);
    tick();                          // T+3 completes
    HRESP = 1'b0;
    #1;
    check("err.T4.rsp_valid", rsp_valid, 2'b01);
    check("err.T4.rsp_err", rsp_err, 1'b1);
    tick();

    // 6: reset while the data phase is stalled
    set_req(1, 64'h6000, 1'b1, 3'b001, 64'h66);
    req_valid = 2'b10;
    tick();                          // T
    req_valid = 2'b00;
    tick();                          // T+1
    HREADY = 1'b0;
    rst    = 1'b1;
    tick();                          // T+2 stalled data phase, reset
    rst       = 1'b0;
    HREADY    = 1'b1;
    req_valid = 2'b11;
    #1;
    check("rstdata.HTRANS", HTRANS, 2'b00);
    check("rstdata.HSEL", HSEL, 1'b0);
    check("rstdata.rsp_valid", rsp_valid, 2'b00);
    check("rstdata.HWDATA", HWDATA, 64'h0);
    check("rstdata.req_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    ticks(4);

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      rst       = ($urandom_range(0, 199) == 0);
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++)
        set_req(i, {$urandom, $urandom}, 1'($urandom), 3'($urandom),
                {$urandom, $urandom});
      HREADY = ($urandom_range(0, 3) != 0);
      HRESP  = ($urandom_range(0, 4) == 0);
      HRDATA = {$urandom, $urandom};
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
